// File: rtl/ball_sprite.sv
// Purpose: frame-stepped pong ball with edge/paddle bounce, miss reporting and a registered sprite pixel stage.
// Latency: position/miss update on the clock edge sampling frame; pixel en/rgb one cycle after x/y.
// Backpressure: none; every input is sampled each cycle and the outputs are always valid.
module ball_sprite #(
   parameter int         WIDTH    = 10,
   parameter int         HEIGHT   = 10,
   parameter logic [1:0] R        = 2'b11,
   parameter logic [1:0] G        = 2'b11,
   parameter logic [1:0] B        = 2'b11,
   parameter int         SCREEN_W = 640,
   parameter int         SCREEN_H = 480,
   parameter int         SPEED_X  = 2,
   parameter int         SPEED_Y  = 2,
   parameter int         START_X  = 320,
   parameter int         START_Y  = 240
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       frame,
   input  logic       collide,
   input  logic       serve,
   output logic [1:0] r,
   output logic [1:0] g,
   output logic [1:0] b,
   output logic       en,
   output logic [9:0] sx,
   output logic [8:0] sy,
   output logic [1:0] miss
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_HIT  = 2'd2
   } state_t;

   // Signed 11-bit constants for the edge tests (no wrap-around in this range).
   localparam logic signed [10:0] W2_S   = 11'(WIDTH / 2);
   localparam logic signed [10:0] H2_S   = 11'(HEIGHT / 2);
   localparam logic signed [10:0] SPX_S  = 11'(SPEED_X);
   localparam logic signed [10:0] SPY_S  = 11'(SPEED_Y);
   localparam logic signed [10:0] SCW_S  = 11'(SCREEN_W);
   localparam logic signed [10:0] SCH_S  = 11'(SCREEN_H);
   localparam logic signed [10:0] ZERO_S = '0;

   // 12-bit constants for the pixel window so sx+W2 can never overflow.
   localparam logic signed [11:0] W2_P = 12'(WIDTH / 2);
   localparam logic signed [11:0] H2_P = 12'(HEIGHT / 2);

   // Register-width constants for the position updates.
   localparam logic [9:0] W2_V      = 10'(WIDTH / 2);
   localparam logic [9:0] SPX_V     = 10'(SPEED_X);
   localparam logic [9:0] START_X_V = 10'(START_X);
   localparam logic [9:0] XMAX_V    = 10'(SCREEN_W - WIDTH / 2);
   localparam logic [8:0] H2_V      = 9'(HEIGHT / 2);
   localparam logic [8:0] SPY_V     = 9'(SPEED_Y);
   localparam logic [8:0] START_Y_V = 9'(START_Y);
   localparam logic [8:0] YMAX_V    = 9'(SCREEN_H - HEIGHT / 2);

   state_t     state_q, state_d;
   logic [9:0] sx_q, sx_d;
   logic [8:0] sy_q, sy_d;
   logic       dx_q, dx_d;        // 0 = right, 1 = left
   logic       dy_q, dy_d;        // 0 = down,  1 = up
   logic       sticky_q, sticky_d;
   logic [1:0] miss_q, miss_d;
   logic       en_q;
   logic [1:0] r_q, g_q, b_q;

   logic signed [10:0] sx_s, sy_s;
   logic signed [10:0] x_left, x_right, y_up, y_down;
   logic               hit;
   logic               en_next;
   logic signed [11:0] px, py, sx_p, sy_p;

   assign sx_s    = signed'({1'b0, sx_q});
   assign sy_s    = signed'({2'b00, sy_q});
   assign x_left  = sx_s - W2_S - SPX_S;
   assign x_right = sx_s + W2_S + SPX_S;
   assign y_up    = sy_s - H2_S - SPY_S;
   assign y_down  = sy_s + H2_S + SPY_S;
   // A collide level in the frame cycle itself counts for this frame.
   assign hit     = sticky_q | collide;

   // Sticky paddle flag: frame and serve clear it, taking priority over a new collide.
   always_comb begin
      sticky_d = sticky_q | collide;
      if (frame || serve) begin
         sticky_d = 1'b0;
      end
   end

   // Next-state: serve (re)launches from IDLE/HIT; frame steps both axes in MOVE.
   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      miss_d  = 2'b00;
      unique case (state_q)
         ST_IDLE, ST_HIT: begin
            // serve wins over a simultaneous frame: reload only, no step.
            if (serve) begin
               state_d = ST_MOVE;
               sx_d    = START_X_V;
               sy_d    = START_Y_V;
            end
         end
         ST_MOVE: begin
            if (frame) begin
               // X axis: paddle bounce beats an edge miss.
               if (hit) begin
                  dx_d = ~dx_q;
                  sx_d = dx_q ? (sx_q + SPX_V) : (sx_q - SPX_V);
               end else if (dx_q && (x_left < ZERO_S)) begin
                  sx_d    = W2_V;
                  miss_d  = 2'b01;
                  state_d = ST_HIT;
               end else if (!dx_q && (x_right > SCW_S)) begin
                  sx_d    = XMAX_V;
                  miss_d  = 2'b10;
                  state_d = ST_HIT;
               end else begin
                  sx_d = dx_q ? (sx_q - SPX_V) : (sx_q + SPX_V);
               end
               // Y axis: bounce off top/bottom, still applied on a miss frame.
               if (dy_q && (y_up < ZERO_S)) begin
                  sy_d = H2_V;
                  dy_d = 1'b0;
               end else if (!dy_q && (y_down > SCH_S)) begin
                  sy_d = YMAX_V;
                  dy_d = 1'b1;
               end else begin
                  sy_d = dy_q ? (sy_q - SPY_V) : (sy_q + SPY_V);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Motion state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sx_q     <= START_X_V;
         sy_q     <= START_Y_V;
         dx_q     <= 1'b0;
         dy_q     <= 1'b0;
         sticky_q <= 1'b0;
         miss_q   <= 2'b00;
      end else begin
         state_q  <= state_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         sticky_q <= sticky_d;
         miss_q   <= miss_d;
      end
   end

   // Half-open window [s-half, s+half) covers exactly WIDTH x HEIGHT pixels.
   assign px      = signed'({2'b00, x});
   assign py      = signed'({2'b00, y});
   assign sx_p    = signed'({2'b00, sx_q});
   assign sy_p    = signed'({3'b000, sy_q});
   assign en_next = (px >= sx_p - W2_P) && (px < sx_p + W2_P) &&
                    (py >= sy_p - H2_P) && (py < sy_p + H2_P);

   // One-cycle registered pixel stage into the colour mux.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q <= 1'b0;
         r_q  <= 2'b00;
         g_q  <= 2'b00;
         b_q  <= 2'b00;
      end else begin
         en_q <= en_next;
         r_q  <= en_next ? R : 2'b00;
         g_q  <= en_next ? G : 2'b00;
         b_q  <= en_next ? B : 2'b00;
      end
   end

   assign en   = en_q;
   assign r    = r_q;
   assign g    = g_q;
   assign b    = b_q;
   assign sx   = sx_q;
   assign sy   = sy_q;
   assign miss = miss_q;

endmodule
